seq_mult_ctrl: RTL
==================

Name: seq_mult_ctrl

Overview:
- Multi-cycle shift-and-add multiplier sequencer. It shares one WIDTH-bit ripple-carry adder across WIDTH iterations instead of using a full array of HA/FA cells.
- Exposes valid/ready handshakes on the operand and product sides.
- Optional truncation of low product bits gives the approximate-multiplier mode used for error/area trade-off studies.
- Sits between the operand source and the result sink, alongside the combinational approximate multipliers, for comparison runs.

Parameters:
- WIDTH, 8, operand width in bits (WIDTH >= 2).
- TRUNC, 0, number of product LSBs forced to zero at the output (0 <= TRUNC < 2*WIDTH); 0 gives an exact product.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands a, b are valid.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  multiplicand, unsigned.
- b  input  WIDTH  multiplier, unsigned.
- out_valid  output  1  product p is valid.
- out_ready  input  1  sink accepts p this cycle.
- p  output  2*WIDTH  product, unsigned.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low; it is sampled only on the rising clk edge.
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, p = 0, internal registers (mcand, acc_hi, mq, cnt) = 0.
- Reset mid-operation: the rule above applies in any state. Any in-flight operation is discarded and no out_valid pulse occurs.
- States: IDLE, RUN, DONE. Encoded as localparams; binary encoding is acceptable.
- in_ready = (state == IDLE). out_valid = (state == DONE). Both are decoded combinationally from registered state.
- IDLE:
  - On in_valid && in_ready: mcand <= a, mq <= b, acc_hi <= 0, cnt <= 0, next state RUN.
  - Otherwise hold.
- RUN, one iteration per cycle:
  - sum, cout = acc_hi + (mq[0] ? mcand : 0), computed by the shared adder.
  - {acc_hi, mq} <= {cout, sum, mq[WIDTH-1:1]}, a right shift of the (2*WIDTH+1)-bit concatenation.
  - cnt <= cnt + 1.
  - When cnt == WIDTH-1, next state DONE and p <= shifted {acc_hi, mq} with bits [TRUNC-1:0] forced to 0.
- cnt width is clog2(WIDTH), computed via a function. It is not wrapped beyond WIDTH-1.
- DONE:
  - p is held stable while out_valid && !out_ready (backpressure of any length).
  - On out_ready: next state IDLE.
  - p keeps its value after the transfer until the next completion.
- Latency: operands are accepted at edge E. out_valid is high from edge E+WIDTH.
- Throughput: minimum one product per WIDTH+2 cycles.
- Simultaneous events:
  - in_valid is ignored outside IDLE. Operands must be held by the source until in_ready.
  - A new operand is never accepted in the same cycle as the output transfer; it is accepted the following cycle in IDLE.
- Arithmetic: unsigned only. The adder carry-out is always captured, so no overflow is possible in 2*WIDTH bits.
- No X propagation: a, b are sampled only on acceptance.

Decomposition:
- Shared package or include file holds:
  - state localparams (IDLE, RUN, DONE);
  - the clog2 function;
  - default WIDTH and TRUNC constants.
- One sub-module: rca_adder #(WIDTH) with ports x, y (WIDTH), s (WIDTH), co (1).
  - Purely combinational; built from one HA at bit 0 and FA cells above it, reusing the existing HA and FA primitives.
  - Instantiated once.

Test Plan:
- WIDTH=8, TRUNC=0: a=13, b=11, out_ready=1 -> in_ready drops the cycle after accept; out_valid rises exactly 8 cycles after accept; p=143 (0x008F).
- Corner operands: a=255, b=255 -> p=65025 (0xFE01); a=0, b=200 -> p=0; a=1, b=255 -> p=255.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> p and out_valid held constant; in_ready stays 0; on out_ready=1, state returns to IDLE next cycle.
- Reset mid-RUN: rst_n=0 at cnt=3 -> after that edge in_ready=1, out_valid=0, p=0; a following a=7, b=9 yields p=63.
- Approximate mode, TRUNC=4: a=13, b=11 -> p=128 (0x0080); a=255, b=255 -> p=65024 (0xFE00).
- Back-to-back stream: 200 random operand pairs with random in_valid/out_ready gaps against a reference model (a*b with low TRUNC bits masked) -> zero mismatches; no product lost or duplicated.

Source files
------------

// File: rtl/seq_mult_ctrl_pkg.sv
// rtl/seq_mult_ctrl_pkg.sv - shared constants and helpers for the sequential multiplier
package seq_mult_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_TRUNC = 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Bits needed to count 0..value-1; never below 1 so counters stay legal.
  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      bits = bits + 1;
    end
    if (bits < 1) begin
      bits = 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/half_adder.sv
// rtl/half_adder.sv - single-bit half adder cell
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/rca_adder.sv
// rtl/rca_adder.sv - combinational ripple-carry adder, HA at bit 0 and FA cells above
module rca_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  logic [WIDTH-1:0] carry;

  half_adder u_ha (
    .a (x[0]),
    .b (y[0]),
    .s (s[0]),
    .c (carry[0])
  );

  for (genvar i = 1; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a  (x[i]),
      .b  (y[i]),
      .ci (carry[i-1]),
      .s  (s[i]),
      .co (carry[i])
    );
  end

  assign co = carry[WIDTH-1];

endmodule

// File: rtl/seq_mult_ctrl.sv
// rtl/seq_mult_ctrl.sv - shift-and-add multiplier sequencer with valid/ready handshakes
module seq_mult_ctrl
  import seq_mult_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int TRUNC = DEFAULT_TRUNC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  // Low TRUNC bits cleared for the approximate mode; all ones when TRUNC is 0.
  localparam logic [2*WIDTH-1:0] KEEP_MASK = {2*WIDTH{1'b1}} << TRUNC;

  logic [1:0]         state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   mq;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] shifted;

  assign addend = mq[0] ? mcand : '0;

  rca_adder #(.WIDTH(WIDTH)) u_adder (
    .x  (acc_hi),
    .y  (addend),
    .s  (sum),
    .co (cout)
  );

  // Carry-out enters at the top so the full product fits in 2*WIDTH bits.
  assign shifted   = {cout, sum, mq[WIDTH-1:1]};
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign p         = prod;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      mcand  <= '0;
      acc_hi <= '0;
      mq     <= '0;
      cnt    <= '0;
      prod   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            mcand  <= a;
            mq     <= b;
            acc_hi <= '0;
            cnt    <= '0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          acc_hi <= shifted[2*WIDTH-1:WIDTH];
          mq     <= shifted[WIDTH-1:0];
          if (cnt == LAST) begin
            prod  <= shifted & KEEP_MASK;
            state <= S_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
